// File: rtl/video_timing_pkg.sv
// Shared timing record and 800x600 reset defaults
// for the video timing generator.
package video_timing_pkg;

  localparam int TW = 16;

  typedef struct packed {
    logic [TW-1:0] hact;
    logic [TW-1:0] hfp;
    logic [TW-1:0] hs;
    logic [TW-1:0] hbp;
    logic [TW-1:0] vact;
    logic [TW-1:0] vfp;
    logic [TW-1:0] vs;
    logic [TW-1:0] vbp;
  } vtiming_t;

  localparam int VT_DEF_HACT = 800;
  localparam int VT_DEF_HFP  = 32;
  localparam int VT_DEF_HS   = 80;
  localparam int VT_DEF_HBP  = 112;
  localparam int VT_DEF_VACT = 600;
  localparam int VT_DEF_VFP  = 3;
  localparam int VT_DEF_VS   = 4;
  localparam int VT_DEF_VBP  = 17;

endpackage

// File: rtl/video_pipe_delay.sv
// En-gated shift register aligning fetch-stage
// timing with the display side.
module video_pipe_delay #(
  parameter int W = 1,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[D-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with early fetch outputs
// and frame-boundary timing reconfiguration.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   XW       = 12,
  parameter int   YW       = 12,
  parameter int   LEAD     = 2,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   DEF_HACT = VT_DEF_HACT,
  parameter int   DEF_HFP  = VT_DEF_HFP,
  parameter int   DEF_HS   = VT_DEF_HS,
  parameter int   DEF_HBP  = VT_DEF_HBP,
  parameter int   DEF_VACT = VT_DEF_VACT,
  parameter int   DEF_VFP  = VT_DEF_VFP,
  parameter int   DEF_VS   = VT_DEF_VS,
  parameter int   DEF_VBP  = VT_DEF_VBP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  output logic          cfg_err,
  input  logic [XW-1:0] cfg_hact,
  input  logic [XW-1:0] cfg_hfp,
  input  logic [XW-1:0] cfg_hs,
  input  logic [XW-1:0] cfg_hbp,
  input  logic [YW-1:0] cfg_vact,
  input  logic [YW-1:0] cfg_vfp,
  input  logic [YW-1:0] cfg_vs,
  input  logic [YW-1:0] cfg_vbp,
  output logic          fetch_valid,
  output logic [XW-1:0] fetch_x,
  output logic [YW-1:0] fetch_y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic          line_start
);

  localparam int HW = XW + 1;
  localparam int VW = YW + 1;
  localparam int PW = XW + YW + 5;
  localparam logic [HW-1:0] H1 = 1;
  localparam logic [VW-1:0] V1 = 1;

  localparam vtiming_t DEF_T = '{
    hact: TW'(DEF_HACT), hfp: TW'(DEF_HFP),
    hs:   TW'(DEF_HS),   hbp: TW'(DEF_HBP),
    vact: TW'(DEF_VACT), vfp: TW'(DEF_VFP),
    vs:   TW'(DEF_VS),   vbp: TW'(DEF_VBP)
  };

  vtiming_t act, shd, cfg_t;
  logic     pending;
  logic     unused_act;

  logic [HW-1:0] hc, h_act, h_ss, h_se, h_tot;
  logic [VW-1:0] vc, v_act, v_ss, v_se, v_tot;
  logic          h_last, v_last, vis;

  assign unused_act = ^act;

  assign h_act = act.hact[HW-1:0];
  assign h_ss  = h_act + act.hfp[HW-1:0];
  assign h_se  = h_ss + act.hs[HW-1:0];
  assign h_tot = h_se + act.hbp[HW-1:0];
  assign v_act = act.vact[VW-1:0];
  assign v_ss  = v_act + act.vfp[VW-1:0];
  assign v_se  = v_ss + act.vs[VW-1:0];
  assign v_tot = v_se + act.vbp[VW-1:0];

  assign h_last = (hc == h_tot - H1);
  assign v_last = (vc == v_tot - V1);
  assign vis    = (hc < h_act) && (vc < v_act);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (en) begin
      if (h_last) begin
        hc <= '0;
        vc <= v_last ? '0 : vc + V1;
      end else begin
        hc <= hc + H1;
      end
    end
  end

  // Two spare bits so an overflowing total is detectable.
  logic [HW:0] c_htot;
  logic [VW:0] c_vtot;
  logic        cfg_zero, cfg_bad, xfer;

  assign c_htot = (HW+1)'(cfg_hact) + (HW+1)'(cfg_hfp)
                + (HW+1)'(cfg_hs) + (HW+1)'(cfg_hbp);
  assign c_vtot = (VW+1)'(cfg_vact) + (VW+1)'(cfg_vfp)
                + (VW+1)'(cfg_vs) + (VW+1)'(cfg_vbp);
  assign cfg_zero = (cfg_hact == '0) || (cfg_hfp == '0)
                 || (cfg_hs == '0) || (cfg_hbp == '0)
                 || (cfg_vact == '0) || (cfg_vfp == '0)
                 || (cfg_vs == '0) || (cfg_vbp == '0);
  assign cfg_bad = cfg_zero || c_htot[HW] || c_vtot[VW];
  assign xfer    = cfg_valid && !pending;
  assign cfg_ready = !pending;

  assign cfg_t = '{
    hact: TW'(cfg_hact), hfp: TW'(cfg_hfp),
    hs:   TW'(cfg_hs),   hbp: TW'(cfg_hbp),
    vact: TW'(cfg_vact), vfp: TW'(cfg_vfp),
    vs:   TW'(cfg_vs),   vbp: TW'(cfg_vbp)
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act     <= DEF_T;
      shd     <= DEF_T;
      pending <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= xfer && cfg_bad;
      if (xfer && !cfg_bad) begin
        shd     <= cfg_t;
        pending <= 1'b1;
      end else if (en && pending && h_last && v_last) begin
        act     <= shd;
        pending <= 1'b0;
      end
    end
  end

  logic f_hs, f_vs, f_fs, f_ls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
      f_hs        <= 1'b0;
      f_vs        <= 1'b0;
      f_fs        <= 1'b0;
      f_ls        <= 1'b0;
    end else if (en) begin
      fetch_valid <= vis;
      fetch_x     <= vis ? hc[XW-1:0] : '0;
      fetch_y     <= vis ? vc[YW-1:0] : '0;
      f_hs        <= (hc >= h_ss) && (hc < h_se);
      f_vs        <= (vc >= v_ss) && (vc < v_se);
      f_fs        <= vis && (hc == '0) && (vc == '0);
      f_ls        <= vis && (hc == '0);
    end
  end

  logic [PW-1:0] p_d, p_q;
  logic          p_hs, p_vs;

  assign p_d = {fetch_valid, fetch_x, fetch_y,
                f_hs, f_vs, f_fs, f_ls};

  video_pipe_delay #(
    .W (PW),
    .D (LEAD)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .d     (p_d),
    .q     (p_q)
  );

  assign {de, x, y, p_hs, p_vs,
          frame_start, line_start} = p_q;

  assign hsync = p_hs ? HS_POL : ~HS_POL;
  assign vsync = p_vs ? VS_POL : ~VS_POL;

endmodule
